// File: rtl/button_pkg.sv
// Shared types and defaults for the button event block.
package button_pkg;

    // Per-channel sequencing state.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        REPEAT = 2'd2
    } btn_state_t;

    // 500 ms hold-off and 100 ms repeat interval at 50 MHz.
    localparam int DEF_HOLD_CYCLES   = 25_000_000;
    localparam int DEF_REPEAT_CYCLES = 5_000_000;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/button_event_fsm.sv
// One button channel: edge pulses plus hold-to-repeat timing.
//
//   state  | meaning
//   IDLE   | button released, counter idle at 0
//   WAIT   | pressed, counting down the hold-off before the first repeat
//   REPEAT | pressed, emitting a repeat tick every REPEAT_CYCLES
module button_event_fsm
    import button_pkg::*;
#(
    parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
    parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    input  logic repeat_en,
    output logic press,
    output logic released,
    output logic rpt,
    output logic step,
    output logic held
);

    localparam int CNT_W = $clog2(max_int(HOLD_CYCLES, REPEAT_CYCLES)) + 1;
    localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_LOAD = CNT_W'(REPEAT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    btn_state_t       state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             press_n, release_n, rpt_n;

    // State, counter and every output are registered; reset clears all of them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            press    <= 1'b0;
            released <= 1'b0;
            rpt      <= 1'b0;
            step     <= 1'b0;
            held     <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            press    <= press_n;
            released <= release_n;
            rpt      <= rpt_n;
            step     <= press_n | rpt_n;
            held     <= btn;
        end
    end

    // Next-state logic; a release always wins over a due repeat tick.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        press_n   = 1'b0;
        release_n = 1'b0;
        rpt_n     = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (btn && !held) begin
                    press_n = 1'b1;
                    cnt_n   = HOLD_LOAD;
                    state_n = WAIT;
                end
            end
            WAIT: begin
                if (!btn) begin
                    release_n = 1'b1;
                    cnt_n     = '0;
                    state_n   = IDLE;
                end else if (cnt == '0) begin
                    if (repeat_en) begin
                        rpt_n   = 1'b1;
                        cnt_n   = REPEAT_LOAD;
                        state_n = REPEAT;
                    end
                end else begin
                    cnt_n = cnt - CNT_ONE;
                end
            end
            REPEAT: begin
                if (!btn) begin
                    release_n = 1'b1;
                    cnt_n     = '0;
                    state_n   = IDLE;
                end else if (!repeat_en) begin
                    cnt_n   = '0;
                    state_n = WAIT;
                end else if (cnt == '0) begin
                    rpt_n = 1'b1;
                    cnt_n = REPEAT_LOAD;
                end else begin
                    cnt_n = cnt - CNT_ONE;
                end
            end
            default: begin
                cnt_n   = '0;
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: rtl/button_events.sv
// Button event generator: N independent channels, no cross-channel arbitration.
// The release pulse is named 'released' because 'release' is a reserved word.
module button_events
    import button_pkg::*;
#(
    parameter int N_BUTTONS     = 5,
    parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
    parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_BUTTONS-1:0] btn,
    input  logic                 repeat_en,
    output logic [N_BUTTONS-1:0] press,
    output logic [N_BUTTONS-1:0] released,
    output logic [N_BUTTONS-1:0] rpt,
    output logic [N_BUTTONS-1:0] step,
    output logic [N_BUTTONS-1:0] held
);

    // One FSM per channel.
    for (genvar g = 0; g < N_BUTTONS; g++) begin : g_ch
        button_event_fsm #(
            .HOLD_CYCLES  (HOLD_CYCLES),
            .REPEAT_CYCLES(REPEAT_CYCLES)
        ) u_fsm (
            .clk      (clk),
            .reset    (reset),
            .btn      (btn[g]),
            .repeat_en(repeat_en),
            .press    (press[g]),
            .released (released[g]),
            .rpt      (rpt[g]),
            .step     (step[g]),
            .held     (held[g])
        );
    end

endmodule

// File: tb/tb_button_events.sv
// Directed bench for button_events with HOLD_CYCLES=8, REPEAT_CYCLES=3, two channels.
module tb_button_events;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] btn = 2'b00;
    logic       repeat_en = 1'b0;
    logic [1:0] press, released, rpt, step, held;
    int         checks = 0;
    int         failures = 0;

    button_events #(
        .N_BUTTONS    (2),
        .HOLD_CYCLES  (8),
        .REPEAT_CYCLES(3)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .btn      (btn),
        .repeat_en(repeat_en),
        .press    (press),
        .released (released),
        .rpt      (rpt),
        .step     (step),
        .held     (held)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        btn = 2'b11;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({press, released, rpt, step, held} !== 10'b0) begin
                failures++;
                $display("FAIL reset_hold cycle %0d: press=%b rel=%b rpt=%b step=%b held=%b, want all 0",
                         i, press, released, rpt, step, held);
            end
        end
        btn = 2'b00;
        #2 reset = 1'b0;
        tick();
        checks++;
        if ({press, released, rpt, step, held} !== 10'b0) begin
            failures++;
            $display("FAIL reset_exit: press=%b rel=%b rpt=%b step=%b held=%b, want all 0",
                     press, released, rpt, step, held);
        end
    endtask

    task automatic test_hold_repeat();
        logic [1:0] ep, er;
        repeat_en = 1'b1;
        btn = 2'b01;
        for (int i = 1; i <= 40; i++) begin
            tick();
            ep = (i == 1) ? 2'b01 : 2'b00;
            er = (i >= 9 && (i - 9) % 3 == 0) ? 2'b01 : 2'b00;
            checks++;
            if (press !== ep || rpt !== er || step !== (ep | er) || released !== 2'b00 || held !== 2'b01) begin
                failures++;
                $display("FAIL hold_repeat cycle %0d: press=%b rpt=%b step=%b rel=%b held=%b, want press=%b rpt=%b step=%b rel=00 held=01",
                         i, press, rpt, step, released, held, ep, er, ep | er);
            end
        end
        btn = 2'b00;
        tick();
        checks++;
        if (released !== 2'b01 || rpt !== 2'b00 || press !== 2'b00 || held !== 2'b00) begin
            failures++;
            $display("FAIL hold_release: rel=%b rpt=%b press=%b held=%b, want rel=01 rpt=00 press=00 held=00",
                     released, rpt, press, held);
        end
        tick();
        checks++;
        if (released !== 2'b00) begin
            failures++;
            $display("FAIL release_width: rel=%b, want 00", released);
        end
    endtask

    task automatic test_short_press();
        int np, nr, nrpt, rel_at;
        np = 0; nr = 0; nrpt = 0; rel_at = 0;
        btn = 2'b01;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (press[0]) np++;
            if (released[0]) begin nr++; rel_at = i; end
            if (rpt[0]) nrpt++;
            if (i == 5) btn = 2'b00;
        end
        checks++;
        if (np != 1 || nr != 1 || nrpt != 0 || rel_at != 6) begin
            failures++;
            $display("FAIL short_press: presses=%0d releases=%0d rpts=%0d release_at=%0d, want 1 1 0 6",
                     np, nr, nrpt, rel_at);
        end
    endtask

    task automatic test_no_repeat();
        logic [1:0] ep, er;
        repeat_en = 1'b0;
        btn = 2'b10;
        for (int i = 1; i <= 20; i++) begin
            tick();
            ep = (i == 1) ? 2'b10 : 2'b00;
            checks++;
            if (press !== ep || rpt !== 2'b00 || step !== ep || held !== 2'b10) begin
                failures++;
                $display("FAIL norpt_hold cycle %0d: press=%b rpt=%b step=%b held=%b, want press=%b rpt=00 step=%b held=10",
                         i, press, rpt, step, held, ep, ep);
            end
        end
        repeat_en = 1'b1;
        for (int j = 1; j <= 10; j++) begin
            tick();
            er = ((j - 1) % 3 == 0) ? 2'b10 : 2'b00;
            checks++;
            if (rpt !== er || step !== er || press !== 2'b00) begin
                failures++;
                $display("FAIL reenable cycle %0d: rpt=%b step=%b press=%b, want rpt=%b step=%b press=00",
                         j, rpt, step, press, er, er);
            end
        end
        btn = 2'b00;
        tick();
        checks++;
        if (released !== 2'b10 || rpt !== 2'b00) begin
            failures++;
            $display("FAIL norpt_release: rel=%b rpt=%b, want rel=10 rpt=00", released, rpt);
        end
        tick();
    endtask

    task automatic test_simultaneous();
        logic [1:0] ep, er, erl;
        logic       due;
        repeat_en = 1'b1;
        btn = 2'b11;
        for (int i = 1; i <= 20; i++) begin
            tick();
            due = (i >= 9 && (i - 9) % 3 == 0);
            ep  = (i == 1) ? 2'b11 : 2'b00;
            er  = {due && i <= 12, due};
            erl = (i == 13) ? 2'b10 : 2'b00;
            checks++;
            if (press !== ep || rpt !== er || released !== erl || step !== (ep | er)) begin
                failures++;
                $display("FAIL simultaneous cycle %0d: press=%b rpt=%b rel=%b step=%b, want press=%b rpt=%b rel=%b step=%b",
                         i, press, rpt, released, step, ep, er, erl, ep | er);
            end
            if (i == 12) btn = 2'b01;
        end
        // cycle 21 is also a due repeat for channel 0
        btn = 2'b00;
        tick();
        checks++;
        if (released !== 2'b01 || rpt !== 2'b00 || step !== 2'b00) begin
            failures++;
            $display("FAIL sim_release_on_due: rel=%b rpt=%b step=%b, want rel=01 rpt=00 step=00",
                     released, rpt, step);
        end
        tick();
    endtask

    task automatic test_release_on_rpt();
        repeat_en = 1'b1;
        btn = 2'b01;
        for (int i = 1; i <= 8; i++) begin
            tick();
            checks++;
            if (press !== ((i == 1) ? 2'b01 : 2'b00) || rpt !== 2'b00) begin
                failures++;
                $display("FAIL pre_due cycle %0d: press=%b rpt=%b, want press=%b rpt=00",
                         i, press, rpt, (i == 1) ? 2'b01 : 2'b00);
            end
        end
        btn = 2'b00;
        tick();
        checks++;
        if (released !== 2'b01 || rpt !== 2'b00 || step !== 2'b00) begin
            failures++;
            $display("FAIL release_on_due: rel=%b rpt=%b step=%b, want rel=01 rpt=00 step=00",
                     released, rpt, step);
        end
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if ({press, released, rpt, step} !== 8'b0) begin
                failures++;
                $display("FAIL after_release cycle %0d: press=%b rel=%b rpt=%b step=%b, want all 0",
                         i, press, released, rpt, step);
            end
        end
    endtask

    task automatic test_reset_mid_repeat();
        logic [1:0] ep, er;
        repeat_en = 1'b1;
        btn = 2'b01;
        for (int i = 1; i <= 9; i++) tick();
        checks++;
        if (rpt !== 2'b01 || step !== 2'b01 || held !== 2'b01) begin
            failures++;
            $display("FAIL pre_reset: rpt=%b step=%b held=%b, want 01 01 01", rpt, step, held);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({press, released, rpt, step, held} !== 10'b0) begin
            failures++;
            $display("FAIL async_reset: press=%b rel=%b rpt=%b step=%b held=%b, want all 0",
                     press, released, rpt, step, held);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({press, released, rpt, step, held} !== 10'b0) begin
                failures++;
                $display("FAIL in_reset cycle %0d: press=%b rel=%b rpt=%b step=%b held=%b, want all 0",
                         i, press, released, rpt, step, held);
            end
        end
        #2 reset = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            ep = (i == 1) ? 2'b01 : 2'b00;
            er = (i == 9 || i == 12) ? 2'b01 : 2'b00;
            checks++;
            if (press !== ep || rpt !== er || released !== 2'b00) begin
                failures++;
                $display("FAIL post_reset cycle %0d: press=%b rpt=%b rel=%b, want press=%b rpt=%b rel=00",
                         i, press, rpt, released, ep, er);
            end
        end
        btn = 2'b00;
        tick();
        checks++;
        if (released !== 2'b01) begin
            failures++;
            $display("FAIL post_reset_release: rel=%b, want 01", released);
        end
        tick();
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_hold_repeat();
        test_short_press();
        test_no_repeat();
        test_simultaneous();
        test_release_on_rpt();
        test_reset_mid_repeat();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
